// File: rtl/store_ring_buf.sv
// Store/write-combining ring buffer: merges byte-strobed writes to pending words and drains them oldest-first.
// Optional byte-granular load forwarding is built when STORE_RING_BUF_FWD_EN is defined.
module store_ring_buf #(
  parameter int BUF_LENGTH      = 8,
  parameter int BUF_LENGTH_BITS = $clog2(BUF_LENGTH),
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ADDR_WIDTH-1:0]            in_addr,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [STRB_WIDTH-1:0]            in_strb,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ADDR_WIDTH-1:0]            out_addr,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [STRB_WIDTH-1:0]            out_strb,
  output logic [BUF_LENGTH_BITS:0]         count,
  input  logic [ADDR_WIDTH-1:0]            lk_addr,
  output logic [STRB_WIDTH-1:0]            lk_hit,
  output logic [DATA_WIDTH-1:0]            lk_data,
  output logic [DATA_WIDTH*BUF_LENGTH-1:0] data_pack
);

  localparam int OFFSET_BITS = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK =
    ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));
  localparam logic [BUF_LENGTH_BITS-1:0] LAST_SLOT  = BUF_LENGTH_BITS'(BUF_LENGTH - 1);
  localparam logic [BUF_LENGTH_BITS:0]   FULL_COUNT = (BUF_LENGTH_BITS + 1)'(BUF_LENGTH);

  logic [BUF_LENGTH-1:0]      ent_valid;
  logic [ADDR_WIDTH-1:0]      ent_addr [BUF_LENGTH];
  logic [DATA_WIDTH-1:0]      ent_data [BUF_LENGTH];
  logic [STRB_WIDTH-1:0]      ent_strb [BUF_LENGTH];
  logic [BUF_LENGTH_BITS-1:0] head;
  logic [BUF_LENGTH_BITS-1:0] tail;

  logic                       merge_hit;
  logic [BUF_LENGTH_BITS-1:0] merge_idx;
  logic [DATA_WIDTH-1:0]      merge_data;
  logic [ADDR_WIDTH-1:0]      in_word;
  logic                       accept;
  logic                       do_merge;
  logic                       do_alloc;
  logic                       do_pop;

  // Pointers wrap explicitly so BUF_LENGTH need not be a power of two.
  function automatic logic [BUF_LENGTH_BITS-1:0] next_ptr(input logic [BUF_LENGTH_BITS-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  assign in_word = in_addr & WORD_MASK;

  // The head may already be on the bus, so it is never a merge target.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < BUF_LENGTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == in_word) && (BUF_LENGTH_BITS'(i) != head)) begin
        merge_hit = 1'b1;
        merge_idx = BUF_LENGTH_BITS'(i);
      end
    end
  end

  always_comb begin
    merge_data = ent_data[merge_idx];
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (in_strb[b]) begin
        merge_data[b*8 +: 8] = in_data[b*8 +: 8];
      end
    end
  end

  assign in_ready  = (count < FULL_COUNT) || merge_hit;
  assign out_valid = (count != '0);
  assign out_addr  = ent_addr[head];
  assign out_data  = ent_data[head];
  assign out_strb  = ent_strb[head];

  assign accept   = in_valid && in_ready && (in_strb != '0);
  assign do_merge = accept && merge_hit;
  assign do_alloc = accept && !merge_hit;
  assign do_pop   = out_valid && out_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ent_valid <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      for (int i = 0; i < BUF_LENGTH; i++) begin
        ent_addr[i] <= '0;
        ent_data[i] <= '0;
        ent_strb[i] <= '0;
      end
    end else begin
      if (do_pop) begin
        ent_valid[head] <= 1'b0;
        head            <= next_ptr(head);
      end
      if (do_merge) begin
        ent_data[merge_idx] <= merge_data;
        ent_strb[merge_idx] <= ent_strb[merge_idx] | in_strb;
      end
      // With a pop in flight the tail slot can never equal the head slot.
      if (do_alloc) begin
        ent_valid[tail] <= 1'b1;
        ent_addr[tail]  <= in_word;
        ent_data[tail]  <= in_data;
        ent_strb[tail]  <= in_strb;
        tail            <= next_ptr(tail);
      end
      case ({do_alloc, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  for (genvar g = 0; g < BUF_LENGTH; g++) begin : g_pack
    assign data_pack[g*DATA_WIDTH +: DATA_WIDTH] = ent_data[g];
  end

`ifdef STORE_RING_BUF_FWD_EN
  logic [ADDR_WIDTH-1:0]      lk_word;
  logic [BUF_LENGTH_BITS-1:0] fwd_idx;

  assign lk_word = lk_addr & WORD_MASK;

  // Walk oldest to youngest so later matches overwrite earlier ones per byte.
  always_comb begin
    lk_hit  = '0;
    lk_data = '0;
    fwd_idx = head;
    for (int k = 0; k < BUF_LENGTH; k++) begin
      if (ent_valid[fwd_idx] && (ent_addr[fwd_idx] == lk_word)) begin
        for (int b = 0; b < STRB_WIDTH; b++) begin
          if (ent_strb[fwd_idx][b]) begin
            lk_hit[b]        = 1'b1;
            lk_data[b*8 +: 8] = ent_data[fwd_idx][b*8 +: 8];
          end
        end
      end
      fwd_idx = next_ptr(fwd_idx);
    end
  end
`else
  logic lk_addr_unused;

  assign lk_addr_unused = ^lk_addr;
  assign lk_hit         = '0;
  assign lk_data        = '0;
`endif

endmodule

// File: tb/tb_store_ring_buf.sv
// Directed bench for store_ring_buf: stimulus pushes expected drained words, a monitor pops and compares.
module tb_store_ring_buf;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_addr = '0;
  logic [31:0]  in_data = '0;
  logic [3:0]   in_strb = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_addr;
  logic [31:0]  out_data;
  logic [3:0]   out_strb;
  logic [3:0]   count;
  logic [31:0]  lk_addr = '0;
  logic [3:0]   lk_hit;
  logic [31:0]  lk_data;
  logic [255:0] data_pack;

  int   applied = 0;
  int   miscompares = 0;
  exp_t sb[$];

  store_ring_buf dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data), .in_strb(in_strb),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .out_strb(out_strb),
    .count(count), .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data), .data_pack(data_pack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectDrain(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.strb = s;
    sb.push_back(e);
  endtask

  // Issues one write and holds it until accepted; ends 1ns after the accepting edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int waited = 0;
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_strb  = s;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 20) begin
        applied++;
        miscompares++;
        $display("[TB] FAIL write_timeout: addr %0h never accepted", a);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drainAll();
    int waited = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (count == 4'd0) break;
      waited++;
      if (waited > 40) begin
        applied++;
        miscompares++;
        $display("[TB] FAIL drain_timeout: count %0d", count);
        break;
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("scoreboard_empty", 256'(sb.size()), 256'd0);
  endtask

  // Monitor: a transfer happens at the next rising edge whenever both sides are high here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          applied++;
          miscompares++;
          $display("[TB] FAIL unexpected_drain: got addr %0h data %0h, expected nothing", out_addr, out_data);
        end else begin
          e = sb.pop_front();
          checkOutput("drain_addr", 256'(out_addr), 256'(e.addr));
          checkOutput("drain_data", 256'(out_data), 256'(e.data));
          checkOutput("drain_strb", 256'(out_strb), 256'(e.strb));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: bench did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset state
    #12;
    checkOutput("reset_out_valid", 256'(out_valid), 256'd0);
    checkOutput("reset_in_ready", 256'(in_ready), 256'd1);
    checkOutput("reset_count", 256'(count), 256'd0);
    checkOutput("reset_out_data", 256'(out_data), 256'd0);
    checkOutput("reset_lk_hit", 256'(lk_hit), 256'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset with three entries pending
    applyStimulus(32'h10, 32'hA1, 4'hF);
    applyStimulus(32'h14, 32'hA2, 4'hF);
    applyStimulus(32'h18, 32'hA3, 4'hF);
    #2;
    checkOutput("pre_reset_count", 256'(count), 256'd3);
    resetn = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", 256'(out_valid), 256'd0);
    checkOutput("async_reset_count", 256'(count), 256'd0);
    checkOutput("async_reset_in_ready", 256'(in_ready), 256'd1);
    checkOutput("async_reset_data_pack", data_pack, 256'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Fill to capacity, then full-buffer in_ready behaviour and a merge into a full buffer
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'(i * 4), 32'h1000 + 32'(i), 4'hF);
    end
    checkOutput("fill_count", 256'(count), 256'd8);
    checkOutput("fill_slot3", 256'(data_pack[127:96]), 256'h1003);
    in_addr = 32'h20;
    #1;
    checkOutput("full_new_addr_ready", 256'(in_ready), 256'd0);
    in_addr = 32'h1C;
    #1;
    checkOutput("full_merge_addr_ready", 256'(in_ready), 256'd1);
    applyStimulus(32'h1E, 32'hFFFF_FFFF, 4'h8);
    checkOutput("full_merge_count", 256'(count), 256'd8);
    for (int i = 0; i < 7; i++) begin
      expectDrain(32'(i * 4), 32'h1000 + 32'(i), 4'hF);
    end
    expectDrain(32'h1C, 32'hFF00_1007, 4'hF);
    drainAll();

    // Merge into a non-head entry
    applyStimulus(32'hF0, 32'h55, 4'hF);
    applyStimulus(32'h100, 32'h1122_3344, 4'h3);
    applyStimulus(32'h101, 32'hAABB_CCDD, 4'hC);
    checkOutput("merge_count", 256'(count), 256'd2);
    checkOutput("merge_slot1_data", 256'(data_pack[63:32]), 256'hAABB_3344);
    expectDrain(32'hF0, 32'h55, 4'hF);
    expectDrain(32'h100, 32'hAABB_3344, 4'hF);
    drainAll();

    // A write matching only the held head allocates a new entry
    applyStimulus(32'h40, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(32'h40, 32'h0000_00AA, 4'h1);
    checkOutput("head_protect_count", 256'(count), 256'd2);
    checkOutput("head_protect_out_data", 256'(out_data), 256'hDEAD_BEEF);
    checkOutput("head_protect_out_addr", 256'(out_addr), 256'h40);
    lk_addr = 32'h43;
    #1;
`ifdef STORE_RING_BUF_FWD_EN
    checkOutput("fwd_head_mix_hit", 256'(lk_hit), 256'hF);
    checkOutput("fwd_head_mix_data", 256'(lk_data), 256'hDEAD_BEAA);
`else
    checkOutput("nofwd_hit", 256'(lk_hit), 256'd0);
    checkOutput("nofwd_data", 256'(lk_data), 256'd0);
`endif
    expectDrain(32'h40, 32'hDEAD_BEEF, 4'hF);
    expectDrain(32'h40, 32'h0000_00AA, 4'h1);
    drainAll();

    // Byte-granular forwarding from head and a younger entry to the same word
    applyStimulus(32'h80, 32'h0000_00AA, 4'h1);
    applyStimulus(32'h80, 32'h0000_BB00, 4'h2);
    lk_addr = 32'h82;
    #1;
`ifdef STORE_RING_BUF_FWD_EN
    checkOutput("fwd_hit", 256'(lk_hit), 256'h3);
    checkOutput("fwd_data", 256'(lk_data), 256'h0000_BBAA);
`else
    checkOutput("nofwd_hit2", 256'(lk_hit), 256'd0);
    checkOutput("nofwd_data2", 256'(lk_data), 256'd0);
`endif
    lk_addr = 32'h84;
    #1;
    checkOutput("fwd_miss_hit", 256'(lk_hit), 256'd0);
    checkOutput("fwd_miss_data", 256'(lk_data), 256'd0);
    expectDrain(32'h80, 32'h0000_00AA, 4'h1);
    expectDrain(32'h80, 32'h0000_BB00, 4'h2);
    drainAll();

    // Drain while writing: first write blocked by the full buffer, then pop+allocate per cycle across the wrap
    for (int i = 0; i < 8; i++) begin
      applyStimulus(32'h200 + 32'(i * 4), 32'h2000 + 32'(i), 4'hF);
      expectDrain(32'h200 + 32'(i * 4), 32'h2000 + 32'(i), 4'hF);
    end
    out_ready = 1'b1;
    in_addr = 32'h300;
    #1;
    checkOutput("full_no_pushthrough", 256'(in_ready), 256'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(32'h300 + 32'(i * 4), 32'h3000 + 32'(i), 4'hF);
      expectDrain(32'h300 + 32'(i * 4), 32'h3000 + 32'(i), 4'hF);
    end
    out_ready = 1'b0;
    #1;
    checkOutput("wrap_count", 256'(count), 256'd7);
    drainAll();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
